multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the MIPS multicycle CPU. Sequences the shared datapath (MUX2/MUX4 selects,
//  ALU, RegisterFile, Memory, PC/IR enable flops) through fetch/decode/execute/writeback per instruction.
//  Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j; memory states stall on mem_ready handshake.
//  Sits beside the datapath; its outputs drive datapath select/enable inputs directly.
// PARAMETERS
//  MAX_WAIT  255  memory-wait cycles in one state before mem_timeout sets (counter width = $clog2(MAX_WAIT+1))
// PORTS
//  clk          in   1  clock, all state updates on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes access this cycle (tie 1 for the combinational-read Memory)
//  i_or_d       out  1  memory address select: 0=PC, 1=ALUOut
//  mem_write    out  1  memory write enable
//  ir_write     out  1  instruction register enable
//  reg_dst      out  1  write reg select: 0=rt, 1=rd
//  mem_to_reg   out  1  writeback select: 0=ALUOut, 1=Data
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
//  alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  pc_src       out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  pc_en        out  1  PC flop enable = pc_write | (branch & zero)
//  instr_done   out  1  1-cycle pulse in final state of each instruction (incl. illegal)
//  illegal_op   out  1  sticky: unsupported opcode/funct decoded; cleared only by reset
//  mem_timeout  out  1  sticky: a memory wait exceeded MAX_WAIT cycles; cleared only by reset
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=FETCH, wait counter=0, sticky flags=0. While rst_n=0, pc_en, ir_write,
//    reg_write, mem_write and instr_done are forced 0; other outputs take FETCH values.
//  - Moore FSM; outputs are a function of state (plus mem_ready, zero where noted). Unlisted outputs = 0.
//  - FETCH: alu_src_b=01, ADD, pc_src=00; ir_write=pc_write=mem_ready. mem_ready ? ->DECODE : stay.
//  - DECODE: alu_src_b=11, ADD (branch target to ALUOut). Next on opcode:
//      100011/101011 ->MEMADR; 000000 ->RTYPEEX if funct in {100000,100010,100100,100101,101010};
//      000100 ->BEQEX; 001000 ->ADDIEX; 000010 ->JEX; anything else ->FETCH, set illegal_op, instr_done=1.
//  - MEMADR: alu_src_a=1, alu_src_b=10, ADD. lw ->MEMRD, sw ->MEMWR.
//  - MEMRD: i_or_d=1. mem_ready ? ->MEMWB : stay.  MEMWB: mem_to_reg=1, reg_write=1, instr_done=1 ->FETCH.
//  - MEMWR: i_or_d=1, mem_write=1 held for whole stall. mem_ready ? (instr_done=1, ->FETCH) : stay.
//  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_control from funct ->RTYPEWB.
//  - RTYPEWB: reg_dst=1, reg_write=1, instr_done=1 ->FETCH.
//  - BEQEX: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, branch=1 (pc_en=zero), instr_done=1 ->FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=10, ADD ->ADDIWB. ADDIWB: reg_write=1, instr_done=1 ->FETCH.
//  - JEX: pc_src=10, pc_write=1, instr_done=1 ->FETCH.
//  - Latency with mem_ready=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2 cycles.
//  - Wait counter: increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0, saturates at MAX_WAIT;
//    reaching MAX_WAIT sets mem_timeout (FSM keeps waiting). Counter clears on any state change.
//  - Reset asserted mid-instruction: immediate abort to FETCH; no partial write enables after deassert.
// STRUCTURE
//  - Package mips_pkg: state_t enum, opcode/funct localparams, alu_control, alu_src_b, pc_src encodings.
//  - Sub-module alu_decoder (combinational): {alu_op[1:0], funct} -> alu_control[2:0], funct_valid.
//  - This module: state register, next-state logic, output decode, wait counter, sticky flags.
// TESTING
//  - Reset mid-RTYPEWB (rst_n low 1 cycle) -> state FETCH, reg_write=0, flags 0, no instr_done.
//  - lw (op 100011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1,mem_to_reg=1 cycle 5.
//  - sw, mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 cycles, instr_done on the mem_ready cycle.
//  - R-type funct 101010 -> alu_control=111 in RTYPEEX; funct 000111 -> illegal_op=1, no reg_write.
//  - beq zero=1 -> pc_en=1, pc_src=01 in BEQEX; zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
//  - MAX_WAIT=4, mem_ready=0 in FETCH for 6 cycles -> mem_timeout=1 from 5th stall cycle, sticky thereafter.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode/funct and datapath select encodings for the multicycle MIPS control path
package mips_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    // ALUOP_NONE leaves alu_control at 000 in states that do not use the ALU
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;
    function automatic logic is_mem_wait(state_t s);
        return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
    endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's ALU operation class and the R-type funct field to an ALU control code
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);
    logic [2:0] funct_ctl;
    always_comb begin
        funct_valid = 1'b1;
        funct_ctl   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            FN_SLT:  funct_ctl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end
    assign alu_control = alu_op == ALUOP_ADD   ? ALU_ADD :
                         alu_op == ALUOP_SUB   ? ALU_SUB :
                         alu_op == ALUOP_FUNCT ? funct_ctl : ALU_AND;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM sequencing the shared MIPS multicycle datapath,
// with memory-wait timeout detection and sticky illegal-instruction reporting
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    state_t state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic [1:0] alu_op;
    logic funct_valid, illegal, stall;
    logic ir_wr, mem_wr, reg_wr, pc_write, branch, done;
    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            illegal_op  <= illegal_op | illegal;
            mem_timeout <= mem_timeout | (stall && wait_nxt == CW'(MAX_WAIT));
        end
    end
    // A stall never changes state, so clearing outside stalls covers every state change
    assign stall    = is_mem_wait(state) && !mem_ready;
    assign wait_nxt = !stall ? '0 : wait_cnt == CW'(MAX_WAIT) ? wait_cnt : wait_cnt + CW'(1);
    always_comb begin
        state_nxt = state;
        illegal   = 1'b0;
        case (state)
            S_FETCH: state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE: begin
                        state_nxt = funct_valid ? S_RTYPEEX : S_FETCH;
                        illegal   = !funct_valid;
                    end
                    OP_BEQ:  state_nxt = S_BEQEX;
                    OP_ADDI: state_nxt = S_ADDIEX;
                    OP_J:    state_nxt = S_JEX;
                    default: begin
                        state_nxt = S_FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_nxt = opcode == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_nxt = S_RTYPEWB;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            default:   state_nxt = S_FETCH;
        endcase
    end
    always_comb begin
        i_or_d     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_NONE;
        pc_src     = PC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        done       = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                ir_wr     = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALUOP_ADD;
                done      = illegal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMRD: i_or_d = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_wr     = 1'b1;
                done       = 1'b1;
            end
            S_MEMWR: begin
                i_or_d = 1'b1;
                mem_wr = 1'b1;
                done   = mem_ready;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                reg_dst = 1'b1;
                reg_wr  = 1'b1;
                done    = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PC_ALUOUT;
                branch    = 1'b1;
                done      = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                reg_wr = 1'b1;
                done   = 1'b1;
            end
            S_JEX: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end
    // Enables are gated by rst_n so nothing fires while reset is held
    assign ir_write   = rst_n & ir_wr;
    assign mem_write  = rst_n & mem_wr;
    assign reg_write  = rst_n & reg_wr;
    assign instr_done = rst_n & done;
    assign pc_en      = rst_n & (pc_write | (branch & zero));
endmodule
